// File: rtl/smc_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : smc_seq_ctrl_if                                                 |
// | Brief    : Beat handshake and result bus for the sequential ID/gm ctrl.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface smc_seq_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] mode;
    logic [2:0] W;
    logic [2:0] V_GS;
    logic [2:0] V_DS;
    logic       out_valid;
    logic [9:0] out_n;

    modport master (
        output in_valid, mode, W, V_GS, V_DS,
        input  in_ready, out_valid, out_n
    );

    modport slave (
        input  in_valid, mode, W, V_GS, V_DS,
        output in_ready, out_valid, out_n
    );
endinterface
`default_nettype wire

// File: rtl/smc_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : smc_seq_ctrl                                                    |
// | Brief    : Time-shared ID/gm calculator with insertion sort and top/bottom |
// |            3 reduction over a serially delivered six-transistor frame.     |
// |            Optional: SMC_GAP_TIMEOUT_EN drops a frame after 8 idle cycles. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module smc_seq_ctrl (
    input  wire logic     clk,
    input  wire logic     rst,
    smc_seq_ctrl_if.slave bus
);
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_SUM  = 2'd2;
    localparam logic [1:0] c_ST_OUT  = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic [1:0] r_mode;
    logic [7:0] r_n [6];
    logic [9:0] r_out_n;
`ifdef SMC_GAP_TIMEOUT_EN
    logic [2:0] r_gap;
    logic [2:0] w_gap_nxt;
`endif

    logic       w_in_ready;
    logic       w_accept;
    logic [9:0] w_ov;
    logic [9:0] w_vds;
    logic [9:0] w_w;
    logic       w_triode;
    logic [9:0] w_id_num;
    logic [9:0] w_gm_num;
    logic [7:0] w_id;
    logic [7:0] w_gm;
    logic       w_sel_id;
    logic [7:0] w_val;
    logic [5:0] w_ge;
    logic [7:0] w_n_ins [6];
    logic [9:0] w_n10 [6];
    logic [9:0] w_sum;

    assign w_in_ready = (r_state == c_ST_IDLE) || (r_state == c_ST_LOAD);
    assign w_accept   = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == c_ST_OUT);
    assign bus.out_n     = r_out_n;

    // Overdrive saturates at zero so V_GS=0 behaves like V_GS=1.
    always_comb begin
        w_ov     = (bus.V_GS == 3'd0) ? 10'd0 : {7'd0, bus.V_GS - 3'd1};
        w_vds    = {7'd0, bus.V_DS};
        w_w      = {7'd0, bus.W};
        w_triode = (w_ov > w_vds);
        if (w_triode) begin
            w_id_num = w_w * ((10'd2 * w_ov * w_vds) - (w_vds * w_vds));
            w_gm_num = 10'd2 * w_w * w_vds;
        end else begin
            w_id_num = w_w * w_ov * w_ov;
            w_gm_num = 10'd2 * w_w * w_ov;
        end
        w_id = 8'(w_id_num / 10'd3);
        w_gm = 8'(w_gm_num / 10'd3);
    end

    // The frame's mode is not latched yet on its first beat, so use the live input.
    assign w_sel_id = (r_state == c_ST_IDLE) ? bus.mode[0] : r_mode[0];
    assign w_val    = w_sel_id ? w_id : w_gm;

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            w_ge[i] = (3'(i) < r_cnt) && (r_n[i] >= w_val);
        end
    end

    // Entries >= new value stay, the slot after them takes it, the rest shift down.
    always_comb begin
        w_n_ins[0] = w_ge[0] ? r_n[0] : w_val;
        for (int i = 1; i < 6; i++) begin
            if (w_ge[i]) begin
                w_n_ins[i] = r_n[i];
            end else if (w_ge[i-1]) begin
                w_n_ins[i] = w_val;
            end else begin
                w_n_ins[i] = r_n[i-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            w_n10[i] = {2'd0, r_n[i]};
        end
        case (r_mode)
            2'b00:   w_sum = w_n10[3] + w_n10[4] + w_n10[5];
            2'b01:   w_sum = (10'd3 * w_n10[3]) + (10'd4 * w_n10[4]) + (10'd5 * w_n10[5]);
            2'b10:   w_sum = w_n10[0] + w_n10[1] + w_n10[2];
            default: w_sum = (10'd3 * w_n10[0]) + (10'd4 * w_n10[1]) + (10'd5 * w_n10[2]);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
`ifdef SMC_GAP_TIMEOUT_EN
        w_gap_nxt   = 3'd0;
`endif
        case (r_state)
            c_ST_IDLE: begin
                w_cnt_nxt = 3'd0;
                if (w_accept) begin
                    w_state_nxt = c_ST_LOAD;
                    w_cnt_nxt   = 3'd1;
                end
            end
            c_ST_LOAD: begin
                if (w_accept) begin
                    if (r_cnt == 3'd5) begin
                        w_state_nxt = c_ST_SUM;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
`ifdef SMC_GAP_TIMEOUT_EN
                else if (r_gap == 3'd7) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_gap_nxt = r_gap + 3'd1;
                end
`endif
            end
            c_ST_SUM: begin
                w_state_nxt = c_ST_OUT;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= 2'd0;
            r_out_n <= 10'd0;
`ifdef SMC_GAP_TIMEOUT_EN
            r_gap   <= 3'd0;
`endif
        end else begin
`ifdef SMC_GAP_TIMEOUT_EN
            r_gap <= w_gap_nxt;
`endif
            if ((r_state == c_ST_IDLE) && w_accept) begin
                r_mode <= bus.mode;
            end
            if (r_state == c_ST_SUM) begin
                r_out_n <= w_sum;
            end else if (r_state == c_ST_OUT) begin
                r_out_n <= 10'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < 6; i++) begin
                r_n[i] <= w_n_ins[i];
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/smc_seq_ctrl.md
# smc_seq_ctrl

Sequential controller that time-shares a single MOSFET ID/gm calculator across a six-transistor frame delivered serially, one transistor per accepted beat. It sorts the per-transistor results by insertion into a descending six-entry register file as they arrive, then applies the mode-selected top-3/bottom-3 reduction and presents a 10-bit result with a one-cycle valid strobe. It replaces the fully parallel six-calculator / sorting-network datapath wherever area matters more than throughput.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  transistor beat present
- in_ready  output  1  controller accepts a beat this cycle
- mode  input  2  frame mode, sampled on the first accepted beat of a frame only
- W  input  3  channel width
- V_GS  input  3  gate-source voltage
- V_DS  input  3  drain-source voltage
- out_valid  output  1  result strobe, one cycle
- out_n  output  10  result, 0 whenever out_valid=0

## Operation
- Beat accepted when in_valid && in_ready. Frame = 6 accepted beats; gaps (in_valid low) are allowed.
- States: IDLE (count=0, in_ready=1), LOAD (1..5 beats held, in_ready=1), SUM (in_ready=0), OUT (in_ready=0, out_valid=1).
- Transitions: IDLE->LOAD on accepted beat; LOAD->SUM on 6th accepted beat; SUM->OUT unconditionally; OUT->IDLE unconditionally. in_valid is ignored in SUM and OUT.
- Calculator, evaluated combinationally on the beat: ov = V_GS-1, saturated at 0 (V_GS=0 gives ov=0). Triode iff ov > V_DS: id = W*(2*ov*V_DS - V_DS^2)/3, gm = 2*W*V_DS/3. Otherwise: id = W*ov^2/3, gm = 2*W*ov/3. All division is floor. Results are 8-bit unsigned (max id=84, gm=28).
- Selected value: id if mode[0]=1, else gm. The mode used is the frame's latched mode; on the first beat, the live mode input is used.
- Insertion: the array n0..n5 is kept descending (n0 largest). A new value is inserted after all entries >= it. Unfilled entries are don't-care.
- Reduction in SUM, 10-bit unsigned, no overflow (max 1008):
  - 00: n3+n4+n5
  - 01: 3*n3+4*n4+5*n5
  - 10: n0+n1+n2
  - 11: 3*n0+4*n1+5*n2
- Result is registered into out_n on the SUM->OUT edge and cleared on the OUT->IDLE edge.

## Timing
- Reset values: state IDLE, count 0, in_ready=1, out_valid=0, out_n=0. Array contents are don't-care.
- Reset mid-frame, or in SUM/OUT: next cycle is IDLE; the partial frame is discarded; no out_valid.
- 6th beat accepted in cycle T: in_ready=0 in T+1 and T+2; out_valid=1 with the result in T+2; in_ready=1 in T+3. The next frame's first beat is accepted no earlier than T+3.
- Minimum frame period: 8 cycles (6 beats + SUM + OUT).
- mode changes after the first beat of a frame have no effect on that frame.

## Configuration
- SMC_GAP_TIMEOUT_EN defined: a 3-bit gap counter runs in LOAD, counts consecutive cycles with in_valid=0, and clears on any accepted beat. When the counter reaches 8 idle cycles, the frame is discarded: next state is IDLE, count=0, no out_valid. A beat arriving in the same cycle as the 8th idle cycle is impossible by definition.
- SMC_GAP_TIMEOUT_EN undefined: no counter; LOAD waits indefinitely.

## Test plan
- Saturation ladder: W=3, V_DS=7, V_GS=1..6 in order, back-to-back. Required out_n per mode: 00 -> 6; 10 -> 24; 01 -> 16; 11 -> 184. Also apply the same ladder in reverse order and random order; results must be identical.
- Max case: six beats W=7, V_GS=7, V_DS=7. Required: mode 11 -> 1008; mode 10 -> 84. out_valid exactly 2 cycles after the 6th beat.
- Triode/floor/V_GS=0: beats (W,V_GS,V_DS) = (3,7,2), (1,3,7), (7,0,5), (3,7,2), (1,3,7), (7,0,5).
  - Per-beat id = 20, 1, 0; per-beat gm = 4, 1, 0.
  - Required: mode 11 -> 3*20+4*20+5*1 = 145; mode 00 -> 1.
- Gaps, mode hold and ignored input: insert 3-cycle in_valid gaps between beats, and toggle mode after the 1st beat; the result uses the first-beat mode. Drive in_valid during SUM/OUT; it must not be accepted and the next frame must be unaffected.
- Reset: assert rst after the 4th beat. Required: no out_valid, in_ready=1 the next cycle, and a following full frame gives the correct result.
- Timeout (SMC_GAP_TIMEOUT_EN defined): 2 beats then 8 idle cycles -> frame dropped, then a fresh 6-beat ladder (mode 00) -> 6. With the macro undefined, the same stimulus gives 6 beats total, and the result uses the first 2 beats plus the first 4 ladder beats.
